// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues in-order word requests to a
// variable-latency instruction memory and buffers returned words in a small FIFO that
// feeds decode over a valid/ready handshake. A redirect flushes the FIFO and arranges
// for responses still in flight to be discarded.
module inst_fetch_unit #(
  parameter logic [31:0] STARTADDR = 32'd0,
  parameter int unsigned DEPTH     = 2
) (
  input  logic        clk,
  input  logic        reset,
  // instruction memory request/response
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  // decode side
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  // control-flow redirect
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  // Counters cover 0..DEPTH; pointers index 0..DEPTH-1.
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW:0]   DepthW  = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] LastPtr = PW'(DEPTH - 1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;

  logic [31:0] data_mem [DEPTH];
  logic [31:0] pc_mem   [DEPTH];

  logic [CW:0]  occupancy;
  logic         fire;
  logic         rsp;
  logic         keep;
  logic         pop;
  logic [31:0]  redirect_aligned;

  assign redirect_aligned = {redirect_pc[31:2], 2'b00};

  // Request credits: buffered plus in-flight words never exceed DEPTH, so a kept
  // response always finds a free FIFO slot.
  assign occupancy = {1'b0, count_q} + {1'b0, inflight_q};
  assign imem_req  = ~reset & ~redirect & (occupancy < DepthW);
  assign imem_addr = fetch_pc_q;

  assign fire = imem_req & imem_ack;
  // A response with nothing outstanding is a memory-side protocol error; ignore it.
  assign rsp  = imem_rvalid & (inflight_q != '0);
  // Responses owed to a discarded stream, or arriving during a redirect, are dropped.
  assign keep = rsp & (drop_cnt_q == '0) & ~redirect;

  assign inst_valid = (count_q != '0);
  assign pop        = inst_valid & inst_ready;

  // Head is masked when empty so stale storage never shows on the outputs.
  assign inst    = inst_valid ? data_mem[head_q] : '0;
  assign inst_pc = inst_valid ? pc_mem[head_q]   : '0;

  // Next-state for PCs, credit counters and FIFO pointers.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q;
    inflight_d = inflight_q + CW'(fire) - CW'(rsp);
    drop_cnt_d = drop_cnt_q;
    head_d     = head_q;
    tail_d     = tail_q;

    if (redirect) begin
      // Everything still outstanding after this cycle belongs to the old stream.
      fetch_pc_d = redirect_aligned;
      resp_pc_d  = redirect_aligned;
      drop_cnt_d = inflight_q - CW'(rsp);
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
    end else begin
      if (fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (rsp && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
      if (keep) begin
        resp_pc_d = resp_pc_q + 32'd4;
        tail_d    = (tail_q == LastPtr) ? '0 : tail_q + PW'(1);
      end
      if (pop) begin
        head_d = (head_q == LastPtr) ? '0 : head_q + PW'(1);
      end
      count_d = count_q + CW'(keep) - CW'(pop);
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= STARTADDR;
      resp_pc_q  <= STARTADDR;
      count_q    <= '0;
      inflight_q <= '0;
      drop_cnt_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  // FIFO storage; contents are only visible through the count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (!reset && keep) begin
      data_mem[tail_q] <= imem_rdata;
      pc_mem[tail_q]   <= resp_pc_q;
    end
  end

endmodule
